// File: rtl/aes_dec_iter_ctrl.sv
// aes_dec_iter_ctrl: iterative AES-128 decryption, one inverse round per clock.
// Optional macro AES_DEC_ABORT_EN adds i_abort to cancel an in-flight block.
module aes_dec_iter_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_ct_in,
  output logic [3:0]   o_rk_idx,
  input  logic [127:0] i_rk_in,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_pt_out,
  output logic         o_busy
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic         i_abort
`endif
);

  // state | meaning
  // IDLE  | waiting for ciphertext; key 10 presented for the initial AddRoundKey
  // ROUND | full inverse round with key r_rnd (9..1)
  // FINAL | last inverse round without InvMixColumns, key 0
  // DONE  | plaintext held in r_st until the consumer takes it
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_st;

  logic         w_abort;
  logic         w_accept;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] sq;
    logic [7:0] acc;
    // undo the affine map, then invert in GF(2^8) as a^254 (zero maps to zero)
    a   = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      o[119-32*c -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      o[111-32*c -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      o[103-32*c -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
    return o;
  endfunction

`ifdef AES_DEC_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_isb = inv_sub_bytes(inv_shift_rows(r_st));
  assign w_ark = w_isb ^ i_rk_in;
  assign w_imc = inv_mix_columns(w_ark);

  assign o_in_ready  = (r_fsm == S_IDLE) && !w_abort;
  assign w_accept    = o_in_ready && i_in_valid;
  assign o_out_valid = (r_fsm == S_DONE);
  assign o_busy      = (r_fsm != S_IDLE);
  assign o_pt_out    = r_st;

  always_comb begin
    o_rk_idx = 4'd0;
    case (r_fsm)
      S_IDLE:  o_rk_idx = 4'd10;
      S_ROUND: o_rk_idx = r_rnd;
      default: o_rk_idx = 4'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm <= S_IDLE;
      r_rnd <= 4'd0;
      r_st  <= '0;
    end else if (w_abort && (r_fsm != S_IDLE)) begin
      r_fsm <= S_IDLE;
      r_rnd <= 4'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_st  <= i_ct_in ^ i_rk_in;
            r_rnd <= 4'd9;
            r_fsm <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st <= w_imc;
          if (r_rnd == 4'd1) begin
            r_rnd <= 4'd0;
            r_fsm <= S_FINAL;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        S_FINAL: begin
          r_st  <= w_ark;
          r_fsm <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) r_fsm <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Bench for aes_dec_iter_ctrl: FIPS-197 C.1 vector, backpressure, back-to-back,
// mid-round reset, random blocks against a round-by-round model, abort when built in.
module tb_aes_dec_iter_ctrl;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_ARK = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  logic [127:0] rk_tab [11];
  logic [7:0]   sbox   [256];
  logic [7:0]   isbox  [256];
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  // bench-side expanded key store, answered combinationally
  assign rk_in = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'd0;

  aes_dec_iter_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_ct_in     (ct_in),
    .o_rk_idx    (rk_idx),
    .i_rk_in     (rk_in),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_pt_out    (pt_out),
    .o_busy      (busy)
`ifdef AES_DEC_ABORT_EN
    ,
    .i_abort     (abort)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // forward S-box from a brute-force field inverse, then invert the table
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = ct[127-8*(r+4*c) -: 8] ^ rk_tab[10][127-8*(r+4*c) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = isbox[s[r][(c-r+4)%4]] ^ rk_tab[rnd][127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd > 0) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ tb_gmul(coef[(k-r+4)%4], t[k][c]);
            s[r][c] = acc;
          end else begin
            s[r][c] = t[r][c];
          end
        end
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] ct, input int hold, input string tag);
    int           n;
    logic [127:0] exp_pt;
    exp_pt = ref_decrypt(ct);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    ct_in = ct; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; ct_in = rand128();
    chk({tag, "_ark"}, pt_out, ct ^ rk_tab[10]);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, 128'(n), 128'd10);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_pt"}, pt_out, exp_pt);
      tick();
    end
    out_ready = 1'b1;
    chk({tag, "_pt"}, pt_out, exp_pt);
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_idle_valid"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    int   cyc;
    int   nacc;
    int   nout;
    int   acc_cyc [2];
    int   out_cyc [2];
    logic seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ct_in = '0;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
`endif
    build_sbox();
    key_expand(FIPS_KEY);
    tick(); tick();
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_rk_idx",    128'(rk_idx),    128'd10);
    chk("rst_pt_out",    pt_out,          128'd0);
    rst = 1'b0;

    // FIPS-197 C.1 with the key-index walk
    ct_in = FIPS_CT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fips_ark",      pt_out,          FIPS_ARK);
    chk("fips_busy",     128'(busy),      128'd1);
    chk("fips_in_ready", 128'(in_ready),  128'd0);
    for (int k = 9; k >= 1; k--) begin
      chk("fips_rk_round", 128'(rk_idx),    128'(k));
      chk("fips_no_valid", 128'(out_valid), 128'd0);
      tick();
    end
    chk("fips_rk_final", 128'(rk_idx), 128'd0);
    tick();
    chk("fips_out_valid", 128'(out_valid), 128'd1);
    chk("fips_pt",        pt_out,          FIPS_PT);
    chk("fips_rk_done",   128'(rk_idx),    128'd0);

    // backpressure in DONE with a competing ciphertext offered
    in_valid = 1'b1; ct_in = rand128();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    128'(out_valid), 128'd1);
      chk("bp_pt",       pt_out,          FIPS_PT);
      chk("bp_in_ready", 128'(in_ready),  128'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_ready", 128'(in_ready),  128'd1);
    chk("bp_rel_valid", 128'(out_valid), 128'd0);
    chk("bp_rel_pt",    pt_out,          FIPS_PT);

    // back-to-back blocks with the consumer always ready
    ct_in = FIPS_CT; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; nacc = 0; nout = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; out_cyc[0] = 0; out_cyc[1] = 0;
    while (nout < 2 && cyc < 60) begin
      if (in_ready && in_valid && nacc < 2) begin acc_cyc[nacc] = cyc; nacc++; end
      if (out_valid) begin
        chk("b2b_pt", pt_out, FIPS_PT);
        if (nout < 2) out_cyc[nout] = cyc;
        nout++;
      end
      tick(); cyc++;
      if (nacc >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_outputs", 128'(nout), 128'd2);
    chk("b2b_period",  128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    chk("b2b_latency", 128'(out_cyc[0] - acc_cyc[0]), 128'd11);

    // reset asserted for the edge E5
    ct_in = rand128(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", 128'(in_ready),  128'd1);
    chk("mrst_valid",    128'(out_valid), 128'd0);
    chk("mrst_busy",     128'(busy),      128'd0);
    chk("mrst_rk_idx",   128'(rk_idx),    128'd10);
    chk("mrst_pt",       pt_out,          128'd0);
    seen = 1'b0;
    repeat (15) begin tick(); if (out_valid) seen = 1'b1; end
    chk("mrst_no_pulse", 128'(seen), 128'd0);
    run_block(FIPS_CT, 0, "post_rst");

    for (int i = 0; i < 6; i++) run_block(rand128(), int'($urandom_range(0, 3)), "rand");

`ifdef AES_DEC_ABORT_EN
    // abort sampled at E7, then held in IDLE against a valid ciphertext
    ct_in = rand128(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    chk("abort_busy",     128'(busy),      128'd0);
    chk("abort_valid",    128'(out_valid), 128'd0);
    chk("abort_in_ready", 128'(in_ready),  128'd0);
    chk("abort_rk_idx",   128'(rk_idx),    128'd10);
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_hold_ready", 128'(in_ready), 128'd0);
      chk("abort_hold_busy",  128'(busy),     128'd0);
    end
    in_valid = 1'b0; abort = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(); if (out_valid) seen = 1'b1; end
    chk("abort_no_pulse", 128'(seen),     128'd0);
    chk("abort_released", 128'(in_ready), 128'd1);
    run_block(FIPS_CT, 1, "post_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
